// File: rtl/ins_fetcher.sv
// rtl/ins_fetcher.sv - instruction fetch stage: PC, JAL prediction, fetch queue toward the decoder
module ins_fetcher #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    IQ_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  Sys_clk,
    input  logic                  Sys_rst,
    input  logic                  Sys_rdy,
    output logic                  IFIC_en,
    output logic [ADDR_WIDTH-1:0] IFIC_addr,
    input  logic                  ICIF_en,
    input  logic [31:0]           ICIF_data,
    input  logic                  RBIF_jump_en,
    input  logic [ADDR_WIDTH-1:0] RBIF_jump_pc,
    output logic                  IFDC_en,
    output logic [31:0]           IFDC_ins,
    output logic [ADDR_WIDTH-1:0] IFDC_pc,
    output logic [ADDR_WIDTH-1:0] IFDC_pred_pc,
    input  logic                  DCIF_pop
);

    localparam int IQ_DEPTH = 1 << IQ_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] pc, pc_nx, addr_nx, npc, jal_off;
    logic                  en_nx;
    logic [20:0]           jal_imm;
    logic                  push, pop, full;

    logic [31:0]           ins_mem  [IQ_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [IQ_DEPTH];
    logic [ADDR_WIDTH-1:0] pred_mem [IQ_DEPTH];
    logic [IQ_WIDTH-1:0]   head, tail;
    logic [IQ_WIDTH:0]     count;

    // count tops out at exactly IQ_DEPTH, so its MSB alone marks a full queue
    assign full    = count[IQ_WIDTH];
    assign jal_imm = {ICIF_data[31], ICIF_data[19:12], ICIF_data[20], ICIF_data[30:21], 1'b0};
    assign jal_off = {{(ADDR_WIDTH-21){jal_imm[20]}}, jal_imm};
    assign npc     = (ICIF_data[6:0] == 7'b1101111) ? pc + jal_off
                                                    : pc + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        en_nx    = IFIC_en;
        addr_nx  = IFIC_addr;
        push     = 1'b0;
        case (state)
            S_IDLE: begin
                if (RBIF_jump_en) begin
                    pc_nx = RBIF_jump_pc;
                end else if (!full) begin
                    en_nx    = 1'b1;
                    addr_nx  = pc;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (RBIF_jump_en) begin
                    pc_nx    = RBIF_jump_pc;
                    en_nx    = 1'b0;
                    state_nx = ICIF_en ? S_IDLE : S_DROP;
                end else if (ICIF_en) begin
                    push     = 1'b1;
                    pc_nx    = npc;
                    en_nx    = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            S_DROP: begin
                en_nx = 1'b0;
                if (RBIF_jump_en) pc_nx = RBIF_jump_pc;
                // The stale reply is the only one outstanding; once it lands there is nothing left to absorb
                if (ICIF_en) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign pop = IFDC_en && DCIF_pop && !RBIF_jump_en;

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            IFIC_en   <= 1'b0;
            IFIC_addr <= RESET_PC;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else if (Sys_rdy) begin
            state     <= state_nx;
            pc        <= pc_nx;
            IFIC_en   <= en_nx;
            IFIC_addr <= addr_nx;
            if (RBIF_jump_en) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge Sys_clk) begin
        if (!Sys_rst && Sys_rdy && push) begin
            ins_mem[tail]  <= ICIF_data;
            pc_mem[tail]   <= pc;
            pred_mem[tail] <= npc;
        end
    end

    assign IFDC_en      = (count != '0);
    assign IFDC_ins     = ins_mem[head];
    assign IFDC_pc      = pc_mem[head];
    assign IFDC_pred_pc = pred_mem[head];

endmodule
